// File: rtl/volume_level_controller_pkg.sv
// Shared constants, types and the sample-to-magnitude helper for the volume level path.
package vol_pkg;
    localparam logic [11:0] MID_SCALE = 12'd2048;
    localparam logic [10:0] MAG_MAX   = 11'd2047;
    localparam logic [3:0]  MAX_LEVEL = 4'd9;

    typedef enum logic [1:0] {IDLE, MAP, UPDATE} vol_state_t;
    typedef logic [3:0] level_t;

    // Distance from mid-scale; only sample=0 reaches 2048, which saturates to 2047.
    function automatic logic [10:0] sample_mag(input logic [11:0] s);
        logic [11:0] d;
        d = (s >= MID_SCALE) ? (s - MID_SCALE) : (MID_SCALE - s);
        return d[11] ? MAG_MAX : d[10:0];
    endfunction
endpackage

// File: rtl/volume_level_controller_peak_window_acc.sv
// Peak tracker over fixed windows of valid samples: holds the closing window's peak
// in snapshot and flags the final sample of each window with window_done.
import vol_pkg::*;

module peak_window_acc #(
    parameter int WINDOW_LEN = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    output logic [10:0] snapshot,
    output logic        window_done
);
    logic [15:0] count;
    logic [10:0] peak;
    logic [10:0] mag;
    logic [10:0] peak_next;

    assign mag         = sample_mag(sample);
    assign peak_next   = (mag > peak) ? mag : peak;
    // The final sample belongs to the closing window, so done is qualified by the strobe itself.
    assign window_done = sample_valid && (count == 16'(WINDOW_LEN - 1));

    // Count valid samples, track the running peak, capture it on the final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            peak     <= '0;
            snapshot <= '0;
        end else if (sample_valid) begin
            if (window_done) begin
                snapshot <= peak_next;
                peak     <= '0;
                count    <= '0;
            end else begin
                peak     <= peak_next;
                count    <= count + 16'd1;
            end
        end
    end
endmodule

// File: rtl/volume_level_controller.sv
// Mic sample stream to 0..9 volume level: window peak, sequential threshold ladder,
// instant attack, one-step release per window, freeze hold.
import vol_pkg::*;

module volume_level_controller #(
    parameter int WINDOW_LEN = 4096,
    parameter int STEP       = 205,
    parameter bit RELEASE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic        freeze,
    output logic [3:0]  volume_level,
    output logic        level_valid,
    output logic        busy
);
    localparam logic [11:0] STEP_W = 12'(STEP);

    logic [10:0] snapshot;
    logic        window_done;
    vol_state_t  state;
    level_t      lvl;
    logic [11:0] thr;

    peak_window_acc #(.WINDOW_LEN(WINDOW_LEN)) u_acc (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .snapshot     (snapshot),
        .window_done  (window_done)
    );

    assign busy = (state != IDLE);

    // Mapping FSM: climb the ladder one band per cycle, then apply attack/release/freeze once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lvl          <= '0;
            thr          <= '0;
            volume_level <= '0;
            level_valid  <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (window_done) begin
                        state <= MAP;
                        lvl   <= '0;
                        thr   <= STEP_W;
                    end
                end
                MAP: begin
                    // snapshot is read live, so an overrun remaps against the newest peak.
                    if (({1'b0, snapshot} >= thr) && (lvl < MAX_LEVEL)) begin
                        lvl <= lvl + 4'd1;
                        thr <= thr + STEP_W;
                    end else begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                    if (!freeze) begin
                        level_valid <= 1'b1;
                        // vol==0 always takes the first branch, so the decrement cannot underflow.
                        if ((lvl >= volume_level) || !RELEASE_EN)
                            volume_level <= lvl;
                        else
                            volume_level <= volume_level - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new window must never close while the previous one is still being mapped.
    assert property (@(posedge clk) disable iff (!rst_n) !(window_done && busy));
endmodule
